// File: rtl/serial_to_parallel_pkg.sv
// Shared types for the serial-to-parallel receiver.
//   s2p_state_t : receive FSM state (IDLE = no bits held, RECV = partial frame held)
package serial_to_parallel_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel_if.sv
// Parallel word handshake between the receiver and its downstream consumer.
//   parallel_o  : assembled word, stable while out_valid_o=1
//   out_valid_o : word available, held until accepted
//   out_ready_i : consumer accepts when out_valid_o & out_ready_i at a rising edge
// master = receiver side, slave = consumer side.
interface serial_to_parallel_if #(
   parameter int unsigned WIDTH = 4
);
   logic [WIDTH-1:0] parallel_o;
   logic             out_valid_o;
   logic             out_ready_i;

   modport master (output parallel_o, output out_valid_o, input out_ready_i);
   modport slave  (input parallel_o, input out_valid_o, output out_ready_i);
endinterface

// File: rtl/s2p_hold_reg.sv
// WIDTH-bit valid/ready holding register with overrun detection.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : a new word is offered this cycle
//   load_data : the offered word
//   ready     : consumer accepts the held word at this edge
//   data      : held word
//   valid     : held word not yet accepted
//   overrun   : 1-cycle pulse, offered word dropped because the register was full
module s2p_hold_reg #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             overrun
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (load) begin
            // An accept on the same edge frees the slot for the new word.
            if (!valid || ready) begin
               data  <= load_data;
               valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_to_parallel.sv
// Receive side of the serial link: samples serial_i while valid_i=1 and reassembles
// WIDTH-bit words (LSB or MSB first), presenting them on a valid/ready handshake.
//   clk, rst    : clock, asynchronous active-high reset
//   serial_i    : serial data bit, sampled only when valid_i=1
//   valid_i     : serial qualifier, low between frames
//   out_if      : parallel word handshake (parallel_o, out_valid_o, out_ready_i)
//   busy_o      : a frame is partially received
//   frame_err_o : 1-cycle pulse, valid_i dropped mid-frame
//   overrun_o   : 1-cycle pulse, completed word dropped because the holding reg was full
module serial_to_parallel
   import serial_to_parallel_pkg::*;
#(
   parameter int unsigned WIDTH     = 4,
   parameter bit          LSB_FIRST = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        serial_i,
   input  logic                        valid_i,
   serial_to_parallel_if.master        out_if,
   output logic                        busy_o,
   output logic                        frame_err_o,
   output logic                        overrun_o
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   s2p_state_t       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sh;
   logic [WIDTH-1:0] next_word;
   logic             complete;

   // The completing bit is folded in combinationally so the word loads on the same edge.
   always_comb begin
      next_word = '0;
      if (LSB_FIRST) next_word = {serial_i, sh[WIDTH-1:1]};
      else           next_word = {sh[WIDTH-2:0], serial_i};
   end

   assign complete = (state == RECV) && valid_i && (cnt == LAST);
   assign busy_o   = (state == RECV);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         sh          <= '0;
         frame_err_o <= 1'b0;
      end else begin
         frame_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_i) begin
                  sh    <= next_word;
                  cnt   <= CW'(1);
                  state <= RECV;
               end
            end
            RECV: begin
               if (valid_i) begin
                  sh <= next_word;
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end else begin
                  frame_err_o <= 1'b1;
                  sh          <= '0;
                  cnt         <= '0;
                  state       <= IDLE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   s2p_hold_reg #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .load      (complete),
      .load_data (next_word),
      .ready     (out_if.out_ready_i),
      .data      (out_if.parallel_o),
      .valid     (out_if.out_valid_o),
      .overrun   (overrun_o)
   );

endmodule

// File: tb/tb_serial_to_parallel.sv
module tb_serial_to_parallel;

   logic clk = 1'b0;
   logic rst;
   logic serial_i, valid_i, ready;
   logic busy, fe, orun;
   logic busy_m, fe_m, orun_m;
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   serial_to_parallel_if #(.WIDTH(4)) bus ();
   serial_to_parallel_if #(.WIDTH(4)) bus_m ();
   assign bus.out_ready_i   = ready;
   assign bus_m.out_ready_i = ready;

   serial_to_parallel #(.WIDTH(4), .LSB_FIRST(1'b1)) dut (
      .clk         (clk),
      .rst         (rst),
      .serial_i    (serial_i),
      .valid_i     (valid_i),
      .out_if      (bus.master),
      .busy_o      (busy),
      .frame_err_o (fe),
      .overrun_o   (orun)
   );

   serial_to_parallel #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_msb (
      .clk         (clk),
      .rst         (rst),
      .serial_i    (serial_i),
      .valid_i     (valid_i),
      .out_if      (bus_m.master),
      .busy_o      (busy_m),
      .frame_err_o (fe_m),
      .overrun_o   (orun_m)
   );

   typedef struct {
      logic       v, s, r;
      logic       ov;
      logic [3:0] par;
      logic       bsy, fe, orun;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic v, s, r, ov, input logic [3:0] par, input logic bsy, fe, orn);
      vec_t e;
      e.v = v; e.s = s; e.r = r; e.ov = ov; e.par = par; e.bsy = bsy; e.fe = fe; e.orun = orn;
      tbl.push_back(e);
   endtask

   task automatic apply(input logic v, s, r);
      valid_i  = v;
      serial_i = s;
      ready    = r;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic ov, input logic [3:0] par,
                      input logic bsy, input logic efe, input logic eorun);
      vectors++;
      if (bus.out_valid_o !== ov || bus.parallel_o !== par || busy !== bsy ||
          fe !== efe || orun !== eorun) begin
         miscompares++;
         $display("FAIL %s: got valid=%b par=%h busy=%b ferr=%b ovr=%b, want valid=%b par=%h busy=%b ferr=%b ovr=%b",
                  name, bus.out_valid_o, bus.parallel_o, busy, fe, orun, ov, par, bsy, efe, eorun);
      end
   endtask

   initial begin
      logic [3:0] words [3];
      logic [3:0] w, rv;

      rst = 1'b1; valid_i = 1'b0; serial_i = 1'b0; ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      // Word 7 (1,1,1,0) held with ready=0, then 2 bits of a new frame, then async reset.
      apply(1, 1, 0); apply(1, 1, 0); apply(1, 1, 0); apply(1, 0, 0);
      chk("pre_reset_word", 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
      apply(1, 1, 0); apply(1, 0, 0);
      chk("pre_reset_busy", 1'b1, 4'h7, 1'b1, 1'b0, 1'b0);
      valid_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("async_reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // v  s  r  | ov par  busy fe orun
      add(1, 0, 1,  0, 4'h0, 1, 0, 0);   // word A = bits 0,1,0,1
      add(1, 1, 1,  0, 4'h0, 1, 0, 0);
      add(1, 0, 1,  0, 4'h0, 1, 0, 0);
      add(1, 1, 1,  1, 4'hA, 0, 0, 0);
      add(0, 0, 1,  0, 4'hA, 0, 0, 0);
      add(0, 0, 1,  0, 4'hA, 0, 0, 0);
      add(1, 1, 1,  0, 4'hA, 1, 0, 0);   // back-to-back 5 then 6
      add(1, 0, 1,  0, 4'hA, 1, 0, 0);
      add(1, 1, 1,  0, 4'hA, 1, 0, 0);
      add(1, 0, 1,  1, 4'h5, 0, 0, 0);
      add(1, 0, 1,  0, 4'h5, 1, 0, 0);
      add(1, 1, 1,  0, 4'h5, 1, 0, 0);
      add(1, 1, 1,  0, 4'h5, 1, 0, 0);
      add(1, 0, 1,  1, 4'h6, 0, 0, 0);
      add(0, 0, 1,  0, 4'h6, 0, 0, 0);
      add(1, 1, 1,  0, 4'h6, 1, 0, 0);   // framing error after 2 bits
      add(1, 1, 1,  0, 4'h6, 1, 0, 0);
      add(0, 0, 1,  0, 4'h6, 0, 1, 0);
      add(0, 0, 1,  0, 4'h6, 0, 0, 0);
      add(1, 1, 1,  0, 4'h6, 1, 0, 0);   // word F
      add(1, 1, 1,  0, 4'h6, 1, 0, 0);
      add(1, 1, 1,  0, 4'h6, 1, 0, 0);
      add(1, 1, 1,  1, 4'hF, 0, 0, 0);
      add(0, 0, 1,  0, 4'hF, 0, 0, 0);
      add(1, 1, 0,  0, 4'hF, 1, 0, 0);   // overrun: 1 then 2 with ready=0
      add(1, 0, 0,  0, 4'hF, 1, 0, 0);
      add(1, 0, 0,  0, 4'hF, 1, 0, 0);
      add(1, 0, 0,  1, 4'h1, 0, 0, 0);
      add(1, 0, 0,  1, 4'h1, 1, 0, 0);
      add(1, 1, 0,  1, 4'h1, 1, 0, 0);
      add(1, 0, 0,  1, 4'h1, 1, 0, 0);
      add(1, 0, 0,  1, 4'h1, 0, 0, 1);
      add(0, 0, 0,  1, 4'h1, 0, 0, 0);
      add(0, 0, 1,  0, 4'h1, 0, 0, 0);
      add(0, 0, 0,  0, 4'h1, 0, 0, 0);
      add(1, 1, 0,  0, 4'h1, 1, 0, 0);   // 1 again, then 2 accepted on completion edge
      add(1, 0, 0,  0, 4'h1, 1, 0, 0);
      add(1, 0, 0,  0, 4'h1, 1, 0, 0);
      add(1, 0, 0,  1, 4'h1, 0, 0, 0);
      add(1, 0, 0,  1, 4'h1, 1, 0, 0);
      add(1, 1, 0,  1, 4'h1, 1, 0, 0);
      add(1, 0, 0,  1, 4'h1, 1, 0, 0);
      add(1, 0, 1,  1, 4'h2, 0, 0, 0);
      add(0, 0, 1,  0, 4'h2, 0, 0, 0);

      foreach (tbl[i]) begin
         apply(tbl[i].v, tbl[i].s, tbl[i].r);
         chk($sformatf("vec%0d", i), tbl[i].ov, tbl[i].par, tbl[i].bsy, tbl[i].fe, tbl[i].orun);
      end

      // Stream from a 4-bit LSB-first transmitter model with one idle cycle between words.
      words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'h9;
      for (int k = 0; k < 3; k++) begin
         w = words[k];
         for (int b = 0; b < 4; b++) apply(1'b1, w[b], 1'b1);
         chk($sformatf("tx_word%0d", k), 1'b1, w, 1'b0, 1'b0, 1'b0);
         for (int b = 0; b < 4; b++) rv[b] = w[3 - b];
         vectors++;
         if (bus_m.out_valid_o !== 1'b1 || bus_m.parallel_o !== rv || fe_m !== 1'b0 || orun_m !== 1'b0) begin
            miscompares++;
            $display("FAIL msb_word%0d: got valid=%b par=%h ferr=%b ovr=%b, want valid=1 par=%h ferr=0 ovr=0",
                     k, bus_m.out_valid_o, bus_m.parallel_o, fe_m, orun_m, rv);
         end
         apply(1'b0, 1'b0, 1'b1);
         chk($sformatf("tx_gap%0d", k), 1'b0, w, 1'b0, 1'b0, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
